// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle byte-addressed data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int DEFAULT_LATENCY = 5;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_array.sv
// Byte storage with synchronous write, registered read and asynchronous clear.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset wipes every byte, so an interrupted store never leaves partial data behind.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            if (re) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_memory.sv
// CPU data memory: fixed-latency load/store with a READ/WRITE/BUSYWAIT stall handshake.
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
    output logic              BUSYWAIT
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state_q;
    op_t               op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              access_now;
    logic              mem_we;
    logic              mem_re;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (READ || WRITE) begin
                        addr_q  <= ADDRESS;
                        data_q  <= WRITEDATA;
                        op_q    <= WRITE ? OP_WRITE : OP_READ;
                        cnt_q   <= CNT_LOAD;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign access_now = (state_q == BUSY) && (cnt_q == '0);
    assign mem_we     = access_now && (op_q == OP_WRITE);
    assign mem_re     = access_now && (op_q == OP_READ);

    // Handshake: the CPU holds READ/WRITE as a level; BUSYWAIT is high from the request
    // cycle through the access edge and drops for the single DONE cycle, where the CPU
    // retires the instruction. Requests seen in DONE are ignored, so a held request is
    // not relaunched.
    assign BUSYWAIT = RESET_N &&
                      (((state_q == IDLE) && (READ || WRITE)) || (state_q == BUSY));

    dmem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .we     (mem_we),
        .re     (mem_re),
        .addr   (addr_q),
        .wdata  (data_q),
        .rdata  (READDATA)
    );

endmodule
